// File: rtl/bf_stage_sequencer_if.sv
// Bus bundle between the FFT stage sequencer and its controller, sample RAM,
// twiddle ROM and butterfly unit. The sequencer uses the master side.
interface bf_stage_sequencer_if #(
  parameter int N_LOG2 = 3,
  parameter int DW     = 8
);
  logic              start;
  logic [N_LOG2-1:0] stage;
  logic              busy;
  logic              done;
  logic              err;

  logic              rd_en;
  logic [N_LOG2-1:0] rd_addr_a;
  logic [N_LOG2-1:0] rd_addr_b;
  logic [2*DW-1:0]   rd_data_a;
  logic [2*DW-1:0]   rd_data_b;

  logic [N_LOG2-2:0] tw_addr;
  logic [DW-1:0]     tw_c;
  logic [DW:0]       tw_c_plus_s;
  logic [DW:0]       tw_c_minus_s;

  logic              start_calc;
  logic [DW-1:0]     A_re;
  logic [DW-1:0]     A_im;
  logic [DW-1:0]     B_re;
  logic [DW-1:0]     B_im;
  logic [DW-1:0]     i_C;
  logic [DW:0]       C_plus_S;
  logic [DW:0]       C_minus_S;

  logic              y_valid;
  logic [2*DW-1:0]   y0;
  logic [2*DW-1:0]   y1;

  logic              wr_en;
  logic [N_LOG2-1:0] wr_addr_a;
  logic [N_LOG2-1:0] wr_addr_b;
  logic [2*DW-1:0]   wr_data_a;
  logic [2*DW-1:0]   wr_data_b;

  modport master (
    input  start, stage, rd_data_a, rd_data_b, tw_c, tw_c_plus_s, tw_c_minus_s,
           y_valid, y0, y1,
    output busy, done, err, rd_en, rd_addr_a, rd_addr_b, tw_addr, start_calc,
           A_re, A_im, B_re, B_im, i_C, C_plus_S, C_minus_S,
           wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b
  );

  modport slave (
    output start, stage, rd_data_a, rd_data_b, tw_c, tw_c_plus_s, tw_c_minus_s,
           y_valid, y0, y1,
    input  busy, done, err, rd_en, rd_addr_a, rd_addr_b, tw_addr, start_calc,
           A_re, A_im, B_re, B_im, i_C, C_plus_S, C_minus_S,
           wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b
  );
endinterface

// File: rtl/bf_stage_sequencer.sv
// Runs one radix-2 DIT FFT stage: per butterfly it reads an operand pair and
// twiddle, fires the butterfly, waits for its result and writes it back in place.
module bf_stage_sequencer #(
  parameter int N_LOG2 = 3,
  parameter int DW     = 8
) (
  input logic                  clk,
  input logic                  reset,
  bf_stage_sequencer_if.master bus
);
  localparam logic [N_LOG2-1:0] LAST_K     = N_LOG2'((1 << (N_LOG2 - 1)) - 1);
  localparam logic [N_LOG2-1:0] TOP_SHIFT  = N_LOG2'(N_LOG2 - 1);
  localparam logic [N_LOG2-1:0] NUM_STAGES = N_LOG2'(N_LOG2);

  typedef enum logic [2:0] {IDLE, READ, LOAD, FIRE, WAIT, WRITE, DONE} state_t;

  state_t            state;
  logic [N_LOG2-1:0] stage_q;
  logic [N_LOG2-1:0] k;

  logic [N_LOG2-1:0] s_sel;
  logic [N_LOG2-1:0] k_sel;
  logic [N_LOG2-1:0] span;
  logic [N_LOG2-1:0] pos;
  logic [N_LOG2-1:0] group;
  logic [N_LOG2-1:0] addr_a;
  logic [N_LOG2-1:0] addr_b;
  logic [N_LOG2-2:0] tw_next;

  // Addresses of the butterfly about to be read: k=0 of the requested stage
  // when leaving IDLE, otherwise k+1 of the latched stage.
  always_comb begin
    s_sel   = (state == IDLE) ? bus.stage : stage_q;
    k_sel   = (state == IDLE) ? '0 : k + N_LOG2'(1);
    span    = N_LOG2'(1) << s_sel;
    pos     = k_sel & (span - N_LOG2'(1));
    group   = k_sel >> s_sel;
    addr_a  = ((group << s_sel) << 1) + pos;
    addr_b  = addr_a + span;
    tw_next = (N_LOG2-1)'(pos << (TOP_SHIFT - s_sel));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      stage_q        <= '0;
      k              <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
      bus.rd_en      <= 1'b0;
      bus.rd_addr_a  <= '0;
      bus.rd_addr_b  <= '0;
      bus.tw_addr    <= '0;
      bus.start_calc <= 1'b0;
      bus.A_re       <= '0;
      bus.A_im       <= '0;
      bus.B_re       <= '0;
      bus.B_im       <= '0;
      bus.i_C        <= '0;
      bus.C_plus_S   <= '0;
      bus.C_minus_S  <= '0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr_a  <= '0;
      bus.wr_addr_b  <= '0;
      bus.wr_data_a  <= '0;
      bus.wr_data_b  <= '0;
    end else begin
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
      bus.rd_en      <= 1'b0;
      bus.start_calc <= 1'b0;
      bus.wr_en      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.stage < NUM_STAGES) begin
              stage_q       <= bus.stage;
              k             <= '0;
              bus.busy      <= 1'b1;
              bus.rd_en     <= 1'b1;
              bus.rd_addr_a <= addr_a;
              bus.rd_addr_b <= addr_b;
              bus.tw_addr   <= tw_next;
              state         <= READ;
            end else begin
              bus.err <= 1'b1;
            end
          end
        end
        READ: state <= LOAD;
        LOAD: begin
          bus.A_re       <= bus.rd_data_a[2*DW-1:DW];
          bus.A_im       <= bus.rd_data_a[DW-1:0];
          bus.B_re       <= bus.rd_data_b[2*DW-1:DW];
          bus.B_im       <= bus.rd_data_b[DW-1:0];
          bus.i_C        <= bus.tw_c;
          bus.C_plus_S   <= bus.tw_c_plus_s;
          bus.C_minus_S  <= bus.tw_c_minus_s;
          bus.start_calc <= 1'b1;
          state          <= FIRE;
        end
        FIRE: state <= WAIT;
        // Read addresses are still held, so they double as write-back addresses.
        WAIT: begin
          if (bus.y_valid) begin
            bus.wr_data_a <= bus.y0;
            bus.wr_data_b <= bus.y1;
            bus.wr_addr_a <= bus.rd_addr_a;
            bus.wr_addr_b <= bus.rd_addr_b;
            bus.wr_en     <= 1'b1;
            state         <= WRITE;
          end
        end
        WRITE: begin
          if (k == LAST_K) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            k             <= k_sel;
            bus.rd_en     <= 1'b1;
            bus.rd_addr_a <= addr_a;
            bus.rd_addr_b <= addr_b;
            bus.tw_addr   <= tw_next;
            state         <= READ;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bf_stage_sequencer.sv
// Directed-plus-random bench for bf_stage_sequencer with a behavioural RAM, ROM
// and butterfly, checked against a reference memory and address schedule.
module tb_bf_stage_sequencer;
   localparam int N_LOG2 = 3;
   localparam int DW     = 8;
   localparam int N      = 1 << N_LOG2;
   localparam int HALF   = N / 2;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   bf_stage_sequencer_if #(.N_LOG2(N_LOG2), .DW(DW)) bus ();

   bf_stage_sequencer #(.N_LOG2(N_LOG2), .DW(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock for the sequencer.
   always #5 clk = ~clk;

   logic [2*DW-1:0] ram     [N];
   logic [2*DW-1:0] ref_mem [N];
   logic [DW-1:0]   rom_c   [HALF];
   logic [DW:0]     rom_p   [HALF];
   logic [DW:0]     rom_m   [HALF];

   int vectors     = 0;
   int miscompares = 0;

   // Record the outcome of one comparison made at the call site.
   task automatic checkOutput(input string tag, input logic passed);
      vectors++;
      if (passed !== 1'b1) begin
         miscompares++;
         $error("[TB] FAIL %s", tag);
      end
   endtask

   // Packs every sequencer output into one vector for reset checking.
   function automatic logic [255:0] all_outputs();
      return 256'({bus.busy, bus.done, bus.err, bus.rd_en, bus.start_calc, bus.wr_en,
                   bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, bus.wr_addr_a, bus.wr_addr_b,
                   bus.A_re, bus.A_im, bus.B_re, bus.B_im, bus.i_C, bus.C_plus_S,
                   bus.C_minus_S, bus.wr_data_a, bus.wr_data_b});
   endfunction

   // One clock step; the synchronous RAM/ROM answer the strobes of the cycle just ended.
   task automatic tick();
      logic re, we;
      logic [N_LOG2-1:0] ra, rb, wa, wb;
      logic [N_LOG2-2:0] ta;
      logic [2*DW-1:0] da, db;
      re = bus.rd_en;  ra = bus.rd_addr_a; rb = bus.rd_addr_b; ta = bus.tw_addr;
      we = bus.wr_en;  wa = bus.wr_addr_a; wb = bus.wr_addr_b;
      da = bus.wr_data_a; db = bus.wr_data_b;
      @(posedge clk);
      #1;
      if (re === 1'b1) begin
         bus.rd_data_a    = ram[ra];
         bus.rd_data_b    = ram[rb];
         bus.tw_c         = rom_c[ta];
         bus.tw_c_plus_s  = rom_p[ta];
         bus.tw_c_minus_s = rom_m[ta];
      end
      if (we === 1'b1) begin
         ram[wa] = da;
         ram[wb] = db;
      end
   endtask

   // Asynchronous reset pulse between clock edges; outputs must clear at once.
   task automatic pulse_reset(input string tag);
      #2 reset = 1'b1;
      #1 checkOutput(tag, all_outputs() === 256'd0);
      #1 reset = 1'b0;
   endtask

   // Runs one stage against the reference schedule, with optional start poke and abort.
   task automatic run_stage(input int s, input int w, input int poke_k, input int abort_k);
      int pa [HALF];
      int pb [HALF];
      int pt [HALF];
      int span, idx, cyc, n;
      logic [2*DW-1:0] ea, eb, y0e, y1e;
      logic [57:0] ops;
      span = 1 << s;
      idx  = 0;
      for (int g = 0; g < N / (2 * span); g++) begin
         for (int p = 0; p < span; p++) begin
            pa[idx] = g * 2 * span + p;
            pb[idx] = pa[idx] + span;
            pt[idx] = p * HALF / span;
            idx++;
         end
      end

      bus.stage = N_LOG2'(s);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      cyc = 1;
      checkOutput($sformatf("s%0d_busy_start", s), bus.busy === 1'b1);

      for (int k = 0; k < HALF; k++) begin
         n = 0;
         while (bus.rd_en !== 1'b1 && n < 16) begin
            tick(); cyc++; n++;
         end
         checkOutput($sformatf("s%0d_k%0d_rd_en", s, k), bus.rd_en === 1'b1);
         checkOutput($sformatf("s%0d_k%0d_rd_addr", s, k),
                     {bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr} ===
                     {N_LOG2'(pa[k]), N_LOG2'(pb[k]), (N_LOG2-1)'(pt[k])});
         ea  = ref_mem[pa[k]];
         eb  = ref_mem[pb[k]];
         y0e = {ea[2*DW-1:DW] + eb[2*DW-1:DW], ea[DW-1:0] + eb[DW-1:0]};
         y1e = {ea[2*DW-1:DW] - eb[2*DW-1:DW], ea[DW-1:0] - eb[DW-1:0]};
         ops = {ea, eb, rom_c[pt[k]], rom_p[pt[k]], rom_m[pt[k]]};
         tick(); cyc++;
         tick(); cyc++;
         checkOutput($sformatf("s%0d_k%0d_start_calc", s, k), bus.start_calc === 1'b1);
         checkOutput($sformatf("s%0d_k%0d_operands", s, k),
                     {bus.A_re, bus.A_im, bus.B_re, bus.B_im, bus.i_C, bus.C_plus_S,
                      bus.C_minus_S} === ops);

         for (int j = 1; j <= w; j++) begin
            if (k == abort_k && j == 2) begin
               pulse_reset("reset_mid_wait");
               for (int i = 0; i < 4; i++) begin
                  tick();
                  checkOutput("abort_no_write", {bus.wr_en, bus.busy} === 2'b00);
               end
               return;
            end
            if (k == poke_k && j == 1) begin
               bus.start = 1'b1;
               bus.stage = N_LOG2'((s + 1) % N_LOG2);
            end
            tick(); cyc++;
            bus.start = 1'b0;
            checkOutput($sformatf("s%0d_k%0d_wait_strobes", s, k),
                        {bus.start_calc, bus.wr_en} === 2'b00);
            checkOutput($sformatf("s%0d_k%0d_ops_stable", s, k),
                        {bus.A_re, bus.A_im, bus.B_re, bus.B_im, bus.i_C, bus.C_plus_S,
                         bus.C_minus_S} === ops);
            if (j == w) begin
               bus.y_valid = 1'b1;
               bus.y0      = y0e;
               bus.y1      = y1e;
            end
         end

         tick(); cyc++;
         bus.y_valid = 1'b0;
         checkOutput($sformatf("s%0d_k%0d_wr_en", s, k), bus.wr_en === 1'b1);
         checkOutput($sformatf("s%0d_k%0d_wr", s, k),
                     {bus.wr_addr_a, bus.wr_addr_b, bus.wr_data_a, bus.wr_data_b} ===
                     {N_LOG2'(pa[k]), N_LOG2'(pb[k]), y0e, y1e});
         ref_mem[pa[k]] = y0e;
         ref_mem[pb[k]] = y1e;
      end

      tick(); cyc++;
      checkOutput($sformatf("s%0d_done", s), {bus.done, bus.busy} === 2'b11);
      checkOutput($sformatf("s%0d_latency", s), cyc === HALF * (4 + w) + 1);
      tick();
      checkOutput($sformatf("s%0d_idle_after", s), {bus.done, bus.busy, bus.wr_en} === 3'b000);
   endtask

   // Main sequence: reset, rejection, spurious strobes, then a series of stages.
   initial begin
      bus.start = 1'b0;  bus.stage = '0;
      bus.rd_data_a = '0; bus.rd_data_b = '0;
      bus.tw_c = '0; bus.tw_c_plus_s = '0; bus.tw_c_minus_s = '0;
      bus.y_valid = 1'b0; bus.y0 = '0; bus.y1 = '0;
      for (int i = 0; i < N; i++) ram[i] = 16'($urandom);
      for (int i = 0; i < HALF; i++) begin
         rom_c[i] = 8'($urandom);
         rom_p[i] = 9'($urandom);
         rom_m[i] = 9'($urandom);
      end
      ram[0] = 16'h6252;  ram[2] = 16'h4632;
      rom_c[0] = 8'h6E;  rom_p[0] = 9'h0AE;  rom_m[0] = 9'h02E;
      for (int i = 0; i < N; i++) ref_mem[i] = ram[i];

      pulse_reset("reset_values");
      tick();

      bus.stage = 3'd3;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      checkOutput("err_pulse", {bus.err, bus.busy} === 2'b10);
      tick();
      checkOutput("err_cleared", {bus.err, bus.busy, bus.rd_en} === 3'b000);

      bus.y_valid = 1'b1;
      bus.y0 = 16'($urandom);
      bus.y1 = 16'($urandom);
      tick();
      bus.y_valid = 1'b0;
      checkOutput("idle_y_valid_ignored", {bus.wr_en, bus.busy} === 2'b00);
      tick();
      checkOutput("idle_y_valid_no_write", bus.wr_en === 1'b0);

      run_stage(1, 1, -1, -1);
      run_stage(0, int'($urandom_range(1, 3)), 2, -1);
      run_stage(2, 5, 1, -1);
      run_stage(2, 6, -1, 2);
      run_stage(2, int'($urandom_range(1, 4)), -1, -1);
      run_stage(1, int'($urandom_range(1, 4)), 0, -1);

      for (int i = 0; i < N; i++) checkOutput($sformatf("ram_%0d", i), ram[i] === ref_mem[i]);

      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
